// File: rtl/bitcoin_pkg.sv
// Shared scan types, sizing constants and the summary word layout.
package bitcoin_pkg;

  localparam int unsigned NUM_NONCES_DEF = 16;
  localparam int unsigned NONCE_W_DEF    = $clog2(NUM_NONCES_DEF);
  localparam int unsigned MEM_RD_LAT     = 2;
  localparam int unsigned ADDR_W         = 16;
  localparam int unsigned DATA_W         = 32;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WB0,
    WB1,
    DONE
  } scan_state_t;

  // Summary word 0: bit 31 = found, low bits = winning nonce index.
  function automatic logic [DATA_W-1:0] pack_summary(input logic found,
                                                     input logic [DATA_W-2:0] nonce);
    return {found, nonce};
  endfunction

endpackage

// File: rtl/nonce_result_scan_if.sv
// Control, result and shared single-port memory signals of the result scanner.
interface nonce_result_scan_if #(
  parameter int unsigned NONCE_W = bitcoin_pkg::NONCE_W_DEF
);

  logic                           start;
  logic [bitcoin_pkg::ADDR_W-1:0] result_addr;
  logic [bitcoin_pkg::DATA_W-1:0] target;
  logic                           done;
  logic                           found;
  logic [NONCE_W-1:0]             best_nonce;
  logic [bitcoin_pkg::DATA_W-1:0] best_value;
  logic                           mem_clk;
  logic                           mem_we;
  logic [bitcoin_pkg::ADDR_W-1:0] mem_addr;
  logic [bitcoin_pkg::DATA_W-1:0] mem_write_data;
  logic [bitcoin_pkg::DATA_W-1:0] mem_read_data;

  modport master (
    input  start, result_addr, target, mem_read_data,
    output done, found, best_nonce, best_value,
           mem_clk, mem_we, mem_addr, mem_write_data
  );

  modport slave (
    output start, result_addr, target, mem_read_data,
    input  done, found, best_nonce, best_value,
           mem_clk, mem_we, mem_addr, mem_write_data
  );

endinterface

// File: rtl/nonce_min_select.sv
// Registered running minimum of a word stream; ties keep the earliest index.
module nonce_min_select #(
  parameter int unsigned NONCE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               valid_i,
  input  logic [31:0]        value_i,
  input  logic [NONCE_W-1:0] index_i,
  output logic [31:0]        best_value_o,
  output logic [NONCE_W-1:0] best_nonce_o
);

  logic [31:0]        best_value_q, best_value_d;
  logic [NONCE_W-1:0] best_nonce_q, best_nonce_d;

  // Strict less-than so an equal later word never displaces the earlier one.
  always_comb begin
    best_value_d = best_value_q;
    best_nonce_d = best_nonce_q;
    if (clear_i) begin
      best_value_d = 32'hFFFF_FFFF;
      best_nonce_d = '0;
    end else if (valid_i && (value_i < best_value_q)) begin
      best_value_d = value_i;
      best_nonce_d = index_i;
    end
  end

  // Minimum state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_value_q <= 32'hFFFF_FFFF;
      best_nonce_q <= '0;
    end else begin
      best_value_q <= best_value_d;
      best_nonce_q <= best_nonce_d;
    end
  end

  assign best_value_o = best_value_q;
  assign best_nonce_o = best_nonce_q;

endmodule

// File: rtl/nonce_result_scan.sv
// Reads back NUM_NONCES hash words, keeps the minimum, writes a 2-word summary.
module nonce_result_scan
  import bitcoin_pkg::*;
#(
  parameter int unsigned NUM_NONCES = NUM_NONCES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  nonce_result_scan_if.master bus
);

  localparam int unsigned NONCE_W = $clog2(NUM_NONCES);
  localparam int unsigned CNT_W   = $clog2(NUM_NONCES + MEM_RD_LAT + 1);
  // cnt_q holds (edges since start - 1); word i lands when cnt_q = i + MEM_RD_LAT - 1.
  localparam logic [CNT_W-1:0] SAMPLE_FIRST = CNT_W'(MEM_RD_LAT - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST  = CNT_W'(NUM_NONCES + MEM_RD_LAT - 2);
  localparam logic [CNT_W-1:0] SCAN_END     = CNT_W'(NUM_NONCES + MEM_RD_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_OFS    = ADDR_W'(NUM_NONCES - 1);
  localparam logic [ADDR_W-1:0] SUM0_OFS    = ADDR_W'(NUM_NONCES);
  localparam logic [ADDR_W-1:0] SUM1_OFS    = ADDR_W'(NUM_NONCES + 1);

  scan_state_t        state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [DATA_W-1:0]  target_q, target_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               found_q, found_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

  logic               min_clear;
  logic               sample_valid;
  logic [NONCE_W-1:0] sample_index;
  logic [DATA_W-1:0]  best_value;
  logic [NONCE_W-1:0] best_nonce;
  logic               found_next;

  assign sample_valid = (state_q == READ) && (cnt_q >= SAMPLE_FIRST) && (cnt_q <= SAMPLE_LAST);
  assign sample_index = NONCE_W'(cnt_q - SAMPLE_FIRST);
  assign found_next   = (best_value < target_q);

  nonce_min_select #(
    .NONCE_W (NONCE_W)
  ) u_min (
    .clk          (clk),
    .rst          (reset),
    .clear_i      (min_clear),
    .valid_i      (sample_valid),
    .value_i      (bus.mem_read_data),
    .index_i      (sample_index),
    .best_value_o (best_value),
    .best_nonce_o (best_nonce)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    found_d     = found_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    min_clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d     = bus.result_addr;
          target_d   = bus.target;
          done_d     = 1'b0;
          min_clear  = 1'b1;
          mem_addr_d = bus.result_addr;
          mem_we_d   = 1'b0;
          cnt_d      = '0;
          state_d    = READ;
        end
      end
      READ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_addr_q != ADDR_W'(base_q + LAST_OFS)) begin
          mem_addr_d = mem_addr_q + ADDR_W'(1);
        end
        if (cnt_q == SCAN_END) begin
          state_d = WB0;
        end
      end
      WB0: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = ADDR_W'(base_q + SUM0_OFS);
        mem_wdata_d = pack_summary(found_next, (DATA_W-1)'(best_nonce));
        found_d     = found_next;
        state_d     = WB1;
      end
      WB1: begin
        mem_addr_d  = ADDR_W'(base_q + SUM1_OFS);
        mem_wdata_d = best_value;
        state_d     = DONE;
      end
      DONE: begin
        mem_we_d = 1'b0;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any scan in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      target_q    <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      found_q     <= found_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.mem_clk        = clk;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_write_data = mem_wdata_q;
  assign bus.done           = done_q;
  assign bus.found          = found_q;
  assign bus.best_nonce     = best_nonce;
  assign bus.best_value     = best_value;

endmodule

// File: tb/tb_nonce_result_scan.sv
// Directed bench for nonce_result_scan with a 2-cycle-latency memory model.
module tb_nonce_result_scan;

  logic clk;
  logic reset;

  nonce_result_scan_if #(.NONCE_W(4)) bus ();

  nonce_result_scan #(.NUM_NONCES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: address on edge k -> read data sampled by the DUT on edge k+2.
  logic [31:0] mem [0:65535];
  logic [31:0] rd_q;
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [31:0] ld_data;
  logic [15:0] watch_addr;
  logic        watch_clr;
  int          wr_watch;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_write_data;
    rd_q <= mem[bus.mem_addr];
    if (watch_clr) wr_watch <= 0;
    else if (bus.mem_we && bus.mem_addr == watch_addr) wr_watch <= wr_watch + 1;
  end
  assign bus.mem_read_data = rd_q;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic load(input logic [15:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic watch(input logic [15:0] a);
    watch_addr = a; watch_clr = 1'b1;
    @(posedge clk); #1;
    watch_clr = 1'b0;
  endtask

  // Count edges after the start edge until done; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = n; break; end
    end
  endtask

  // Target is scrambled after the start edge to show it was latched.
  task automatic run_scan(input logic [15:0] base, input logic [31:0] tgt, output int lat);
    bus.result_addr = base; bus.target = tgt; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.target = ~tgt; bus.result_addr = ~base;
    wait_done(lat);
  endtask

  int lat;

  initial begin
    reset = 1'b1; bus.start = 1'b0; bus.result_addr = '0; bus.target = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; watch_addr = '0; watch_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst done", 32'(bus.done), 32'd0);
    check("rst found", 32'(bus.found), 32'd0);
    check("rst nonce", 32'(bus.best_nonce), 32'd0);
    check("rst value", bus.best_value, 32'hFFFF_FFFF);
    check("rst we", 32'(bus.mem_we), 32'd0);
    check("rst addr", 32'(bus.mem_addr), 32'd0);
    check("rst wdata", bus.mem_write_data, 32'd0);
    reset = 1'b0; watch_clr = 1'b0;

    // Ascending words, minimum at index 0, target just above it.
    for (int i = 0; i < 16; i++) load(16'(16'h0100 + i), 32'(100 + i));
    run_scan(16'h0100, 32'd101, lat);
    check("t1 latency", 32'(lat), 32'd21);
    check("t1 value", bus.best_value, 32'd100);
    check("t1 nonce", 32'(bus.best_nonce), 32'd0);
    check("t1 found", 32'(bus.found), 32'd1);
    check("t1 sum0", mem[16'h0110], 32'h8000_0000);
    check("t1 sum1", mem[16'h0111], 32'd100);
    check("t1 we low", 32'(bus.mem_we), 32'd0);

    // Descending words, minimum at last index, target 0.
    for (int i = 0; i < 16; i++) load(16'(16'h0200 + i), 32'hFFFF_FFF0 - 32'(i));
    run_scan(16'h0200, 32'd0, lat);
    check("t2 latency", 32'(lat), 32'd21);
    check("t2 value", bus.best_value, 32'hFFFF_FFE1);
    check("t2 nonce", 32'(bus.best_nonce), 32'd15);
    check("t2 found", 32'(bus.found), 32'd0);
    check("t2 sum0", mem[16'h0210], 32'h0000_000F);
    check("t2 sum1", mem[16'h0211], 32'hFFFF_FFE1);

    // Ties: 5,9,3,3,7 then larger words; first 3 wins.
    load(16'h0300, 32'd5); load(16'h0301, 32'd9); load(16'h0302, 32'd3);
    load(16'h0303, 32'd3); load(16'h0304, 32'd7);
    for (int i = 5; i < 16; i++) load(16'(16'h0300 + i), 32'(1000 + i));
    run_scan(16'h0300, 32'hFFFF_FFFF, lat);
    check("t3 value", bus.best_value, 32'd3);
    check("t3 nonce", 32'(bus.best_nonce), 32'd2);
    check("t3 found", 32'(bus.found), 32'd1);
    check("t3 sum0", mem[16'h0310], 32'h8000_0002);

    // Address wrap from FFF8; min 7 at index 10 (address 0002), target equal to min.
    for (int i = 0; i < 16; i++) load(16'(16'hFFF8 + i), (i == 10) ? 32'd7 : 32'(32'h1000 + i));
    run_scan(16'hFFF8, 32'd7, lat);
    check("t4 latency", 32'(lat), 32'd21);
    check("t4 value", bus.best_value, 32'd7);
    check("t4 nonce", 32'(bus.best_nonce), 32'd10);
    check("t4 found", 32'(bus.found), 32'd0);
    check("t4 sum0", mem[16'h0008], 32'h0000_000A);
    check("t4 sum1", mem[16'h0009], 32'd7);

    // All words FFFFFFFF with target FFFFFFFF: not found.
    for (int i = 0; i < 16; i++) load(16'(16'h0400 + i), 32'hFFFF_FFFF);
    run_scan(16'h0400, 32'hFFFF_FFFF, lat);
    check("t5 value", bus.best_value, 32'hFFFF_FFFF);
    check("t5 nonce", 32'(bus.best_nonce), 32'd0);
    check("t5 found", 32'(bus.found), 32'd0);
    check("t5 sum0", mem[16'h0410], 32'h0000_0000);

    // Reset at edge 8 of a scan aborts it with no summary write.
    for (int i = 0; i < 16; i++) load(16'(16'h0500 + i), 32'(100 + i));
    load(16'h0510, 32'hDEAD_BEEF);
    watch(16'h0510);
    bus.result_addr = 16'h0500; bus.target = 32'd101; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1; reset = 1'b1; #1;
    check("t6 rst done", 32'(bus.done), 32'd0);
    check("t6 rst value", bus.best_value, 32'hFFFF_FFFF);
    check("t6 rst nonce", 32'(bus.best_nonce), 32'd0);
    check("t6 rst addr", 32'(bus.mem_addr), 32'd0);
    check("t6 rst we", 32'(bus.mem_we), 32'd0);
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("t6 no write", 32'(wr_watch), 32'd0);
    check("t6 sentinel", mem[16'h0510], 32'hDEAD_BEEF);
    check("t6 done idle", 32'(bus.done), 32'd0);
    run_scan(16'h0500, 32'd101, lat);
    check("t6 re latency", 32'(lat), 32'd21);
    check("t6 re value", bus.best_value, 32'd100);
    check("t6 re sum0", mem[16'h0510], 32'h8000_0000);

    // start held high: one summary write per scan, clean restart after DONE.
    for (int i = 0; i < 16; i++) load(16'(16'h0600 + i), 32'(100 + i));
    watch(16'h0610);
    bus.result_addr = 16'h0600; bus.target = 32'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    wait_done(lat);
    check("t7 latency", 32'(lat), 32'd21);
    check("t7 writes 1", 32'(wr_watch), 32'd1);
    check("t7 sum0", mem[16'h0610], 32'h0000_0000);
    @(posedge clk); #1;
    check("t7 restart", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    wait_done(lat);
    check("t7 latency 2", 32'(lat), 32'd21);
    check("t7 writes 2", 32'(wr_watch), 32'd2);
    check("t7 value", bus.best_value, 32'd100);
    check("t7 sum1", mem[16'h0611], 32'd100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
